// File: rtl/sym_restore_if.sv
// Handshake bundle for sym_restore: sign FIFO input, folded result input,
// restored result output and status.
//
// Handshake rule (all three channels): a transfer happens on the rising clk
// edge where valid and ready are both high; ready never depends on valid.
interface sym_restore_if #(
    parameter int M     = 4,
    parameter int N     = 8,
    parameter int DEPTH = 4
);
    localparam int W  = M + N;
    localparam int LW = $clog2(DEPTH) + 1;

    logic                sign_valid;
    logic                sign_in;
    logic                sign_ready;
    logic                y_valid;
    logic signed [W-1:0] y_in;
    logic                y_ready;
    logic                out_valid;
    logic signed [W-1:0] out_y;
    logic                out_ready;
    logic [LW-1:0]       level;
    logic                err;

    // Producer / consumer side (testbench or surrounding pipeline).
    modport master (
        output sign_valid, sign_in, y_valid, y_in, out_ready,
        input  sign_ready, y_ready, out_valid, out_y, level, err
    );

    // The restore block itself.
    modport slave (
        input  sign_valid, sign_in, y_valid, y_in, out_ready,
        output sign_ready, y_ready, out_valid, out_y, level, err
    );
endinterface

// File: rtl/sym_restore.sv
// sym_restore: undoes an input-axis fold. Signs from the fold stage are queued
// in a small FIFO; each folded approximator result pops the oldest sign and is
// mapped back to the unfolded domain (odd or point-about-(0,0.5) symmetry).
// Optional feature macro: SYM_RESTORE_SAT_EN -- saturate the restored value
// instead of wrapping it to M+N bits.
module sym_restore #(
    parameter int M        = 4,
    parameter int N        = 8,
    parameter int SYM_TYPE = 0,
    parameter int DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    sym_restore_if.slave bus
);
    localparam int W  = M + N;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // 1.0 in the fixed-point format, held one bit wider than the datapath.
    localparam logic signed [W:0] ONE_WIDE = (W+1)'(1) << N;
`ifdef SYM_RESTORE_SAT_EN
    localparam logic signed [W-1:0] MAX_Y = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_Y = {1'b1, {(W-1){1'b0}}};
`endif

    logic [DEPTH-1:0]    sign_mem_q;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                out_valid_q, out_valid_d;
    logic signed [W-1:0] out_y_q, out_y_d;
    logic                err_q, err_d;

    logic                full, empty, push, pop, head_sign;
    logic signed [W:0]   y_ext, r_wide;
    logic signed [W-1:0] r_red;

    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign head_sign = sign_mem_q[rd_ptr_q];

    // A full FIFO refuses pushes even if a pop frees a slot in the same cycle.
    assign bus.sign_ready = !full;
    assign bus.y_ready    = !empty && (!out_valid_q || bus.out_ready);
    assign push           = bus.sign_valid && !full;
    assign pop            = bus.y_valid && bus.y_ready;

    // Restore the folded value at one extra bit so -(-2^(W-1)) is exact.
    always_comb begin
        y_ext  = {bus.y_in[W-1], bus.y_in};
        r_wide = y_ext;
        if (head_sign) begin
            if (SYM_TYPE == 0) r_wide = -y_ext;
            else               r_wide = ONE_WIDE - y_ext;
        end
    end

    // Bring the wide result back to W bits: clamp or two's-complement wrap.
    always_comb begin
        r_red = $signed(r_wide[W-1:0]);
`ifdef SYM_RESTORE_SAT_EN
        if (r_wide[W] != r_wide[W-1]) begin
            r_red = r_wide[W] ? MIN_Y : MAX_Y;
        end
`endif
    end

    // Next-state for pointers, occupancy, output register and error flag.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        err_d       = err_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (pop) begin
            out_valid_d = 1'b1;
            out_y_d     = r_red;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if ((bus.y_valid && empty) || (bus.sign_valid && full)) err_d = 1'b1;
    end

    // Sign storage: written only on an accepted push; contents are don't-care
    // outside the occupied window so they need no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) sign_mem_q[wr_ptr_q] <= bus.sign_in;
    end

    // State registers with synchronous reset that drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.level     = level_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_sym_restore.sv
// Bench for sym_restore: two instances (odd and point symmetry) share one
// stimulus stream; a queue-based model checks both every cycle, and directed
// literal expectations pin the model.
module tb_sym_restore;
    localparam int M     = 4;
    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int W     = M + N;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                sv, si, yv, ordy;
    logic signed [W-1:0] yi;

    int checks = 0;
    int errors = 0;

    sym_restore_if #(.M(M), .N(N), .DEPTH(DEPTH)) bus0 ();
    sym_restore_if #(.M(M), .N(N), .DEPTH(DEPTH)) bus1 ();

    assign bus0.sign_valid = sv;
    assign bus0.sign_in    = si;
    assign bus0.y_valid    = yv;
    assign bus0.y_in       = yi;
    assign bus0.out_ready  = ordy;
    assign bus1.sign_valid = sv;
    assign bus1.sign_in    = si;
    assign bus1.y_valid    = yv;
    assign bus1.y_in       = yi;
    assign bus1.out_ready  = ordy;

    sym_restore #(.M(M), .N(N), .SYM_TYPE(0), .DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    sym_restore #(.M(M), .N(N), .SYM_TYPE(1), .DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    bit sq[$];
    bit m_ov;
    int m_y0, m_y1;
    bit m_err;
    bit live = 1'b0;

    function automatic int restore(int sym, bit s, int y);
        int r;
        r = y;
        if (s) r = (sym == 0) ? -y : ((1 << N) - y);
`ifdef SYM_RESTORE_SAT_EN
        if (r > (1 << (W-1)) - 1) r = (1 << (W-1)) - 1;
        if (r < -(1 << (W-1)))    r = -(1 << (W-1));
`else
        r = r & ((1 << W) - 1);
        if (r >= (1 << (W-1))) r = r - (1 << W);
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        bit can_push, can_pop, s;
        if (rst) begin
            sq.delete();
            m_ov  = 1'b0;
            m_y0  = 0;
            m_y1  = 0;
            m_err = 1'b0;
            live  = 1'b1;
        end else begin
            can_push = sq.size() < DEPTH;
            can_pop  = (sq.size() != 0) && (!m_ov || ordy);
            if ((yv && sq.size() == 0) || (sv && sq.size() == DEPTH)) m_err = 1'b1;
            if (yv && can_pop) begin
                s    = sq.pop_front();
                m_ov = 1'b1;
                m_y0 = restore(0, s, int'(yi));
                m_y1 = restore(1, s, int'(yi));
            end else if (ordy) begin
                m_ov = 1'b0;
            end
            if (sv && can_push) sq.push_back(si);
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input logic sr, input logic yr,
                             input logic ov, input logic signed [W-1:0] oy,
                             input logic [LW-1:0] lvl, input logic e, input int exp_y);
        int m_sr, m_yr;
        m_sr = (sq.size() < DEPTH) ? 1 : 0;
        m_yr = ((sq.size() != 0) && (!m_ov || ordy)) ? 1 : 0;
        chk({tag, ".sign_ready"}, int'(sr), m_sr);
        chk({tag, ".y_ready"}, int'(yr), m_yr);
        chk({tag, ".out_valid"}, int'(ov), int'(m_ov));
        chk({tag, ".level"}, int'(lvl), sq.size());
        chk({tag, ".err"}, int'(e), int'(m_err));
        if (m_ov) chk({tag, ".out_y"}, int'(oy), exp_y);
    endtask

    // Per-cycle compare away from the active edge.
    always @(negedge clk) begin
        if (live) begin
            check_dut("dut0", bus0.sign_ready, bus0.y_ready, bus0.out_valid,
                      bus0.out_y, bus0.level, bus0.err, m_y0);
            check_dut("dut1", bus1.sign_ready, bus1.y_ready, bus1.out_valid,
                      bus1.out_y, bus1.level, bus1.err, m_y1);
        end
    end

    // ---------------- driver ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sv = 1'b0; si = 1'b0; yv = 1'b0; yi = '0; ordy = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_level", int'(bus0.level), 0);
        chk("rst_out_valid", int'(bus0.out_valid), 0);
        chk("rst_err", int'(bus0.err), 0);
        chk("rst_sign_ready", int'(bus0.sign_ready), 1);
        chk("rst_y_ready", int'(bus0.y_ready), 0);

        // Signs 1,0 then y=100 twice.
        sv = 1'b1; si = 1'b1; cyc();
        si = 1'b0; cyc();
        sv = 1'b0;
        chk("odd_level2", int'(bus0.level), 2);
        yv = 1'b1; yi = 12'sd100; cyc();
        chk("odd_first_valid", int'(bus0.out_valid), 1);
        chk("odd_first_y", int'(bus0.out_y), -100);
        chk("pt_first_y", int'(bus1.out_y), 156);
        chk("odd_level1", int'(bus0.level), 1);
        cyc();
        chk("odd_second_y", int'(bus0.out_y), 100);
        chk("odd_level0", int'(bus0.level), 0);
        yv = 1'b0; cyc();
        chk("odd_drained_valid", int'(bus0.out_valid), 0);

        // Point symmetry: 0.25 mirrored -> 0.75; unmirrored stays 0.25.
        sv = 1'b1; si = 1'b1; cyc();
        sv = 1'b0; yv = 1'b1; yi = 12'sd64; cyc();
        chk("pt_mirror_y", int'(bus1.out_y), 192);
        chk("odd_mirror64_y", int'(bus0.out_y), -64);
        yv = 1'b0; sv = 1'b1; si = 1'b0; cyc();
        sv = 1'b0; yv = 1'b1; yi = 12'sd64; cyc();
        chk("pt_plain_y", int'(bus1.out_y), 64);
        yv = 1'b0; cyc();

        // Simultaneous push and pop keeps level and order.
        sv = 1'b1; si = 1'b0; cyc();
        si = 1'b1; yv = 1'b1; yi = 12'sd5; cyc();
        chk("pushpop_y", int'(bus0.out_y), 5);
        chk("pushpop_level", int'(bus0.level), 1);
        sv = 1'b0; yi = 12'sd6; cyc();
        chk("pushpop_next_y", int'(bus0.out_y), -6);
        yv = 1'b0; cyc();

        // Fill to DEPTH, then overflow attempt.
        sv = 1'b1;
        si = 1'b1; cyc();
        si = 1'b0; cyc();
        si = 1'b1; cyc();
        si = 1'b1; cyc();
        chk("full_sign_ready", int'(bus0.sign_ready), 0);
        chk("full_level", int'(bus0.level), 4);
        chk("full_err_before", int'(bus0.err), 0);
        si = 1'b0; cyc();
        chk("overflow_err", int'(bus0.err), 1);
        chk("overflow_level", int'(bus0.level), 4);
        sv = 1'b0;

        // Output stall then back-to-back drain.
        ordy = 1'b0; yv = 1'b1; yi = 12'sd10; cyc();
        chk("stall_first_y", int'(bus0.out_y), -10);
        yi = 12'sd20; cyc();
        chk("stall_y_ready", int'(bus0.y_ready), 0);
        chk("stall_hold_y", int'(bus0.out_y), -10);
        cyc();
        chk("stall_hold_y2", int'(bus0.out_y), -10);
        chk("stall_level", int'(bus0.level), 3);
        ordy = 1'b1; cyc();
        chk("b2b_y1", int'(bus0.out_y), 20);
        yi = 12'sd30; cyc();
        chk("b2b_y2", int'(bus0.out_y), -30);
        chk("b2b_valid", int'(bus0.out_valid), 1);
        yi = 12'sd40; cyc();
        chk("b2b_y3", int'(bus0.out_y), -40);
        chk("b2b_level", int'(bus0.level), 0);
        yv = 1'b0; cyc();

        // Reset in the middle of traffic.
        sv = 1'b1; si = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        sv = 1'b0; ordy = 1'b0; yv = 1'b1; yi = 12'sd7; cyc();
        yv = 1'b0;
        chk("pre_rst_level", int'(bus0.level), 3);
        chk("pre_rst_valid", int'(bus0.out_valid), 1);
        rst = 1'b1; sv = 1'b1; yv = 1'b1; cyc();
        chk("mid_rst_level", int'(bus0.level), 0);
        chk("mid_rst_valid", int'(bus0.out_valid), 0);
        chk("mid_rst_err", int'(bus0.err), 0);
        chk("mid_rst_sign_ready", int'(bus0.sign_ready), 1);
        rst = 1'b0;
        idle();
        cyc();

        // Most negative input, mirrored.
        sv = 1'b1; si = 1'b1; cyc();
        sv = 1'b0; yv = 1'b1; yi = -12'sd2048; cyc();
`ifdef SYM_RESTORE_SAT_EN
        chk("minneg_odd_y", int'(bus0.out_y), 2047);
        chk("minneg_pt_y", int'(bus1.out_y), 2047);
`else
        chk("minneg_odd_y", int'(bus0.out_y), -2048);
        chk("minneg_pt_y", int'(bus1.out_y), -1792);
`endif
        yv = 1'b0; cyc();

        // y_valid with nothing queued raises err.
        chk("underflow_err_before", int'(bus0.err), 0);
        yv = 1'b1; yi = 12'sd3; cyc();
        chk("underflow_err", int'(bus0.err), 1);
        chk("underflow_no_pop", int'(bus0.out_valid), 0);
        yv = 1'b0; cyc();

        // Mixed traffic, checked cycle-by-cycle by the model.
        rst = 1'b1; cyc();
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            sv   = 1'($urandom_range(0, 1));
            si   = 1'($urandom_range(0, 1));
            yv   = 1'($urandom_range(0, 1));
            yi   = W'($urandom_range(0, (1 << W) - 1));
            ordy = ($urandom_range(0, 3) != 0);
            cyc();
        end
        idle();
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sym_restore.md
SYM_RESTORE -- requirements
Module: sym_restore

Interface
REQ-001 SHALL have parameter M, default 4, integer bits of the datapath including the sign bit.
REQ-002 SHALL have parameter N, default 8, fractional bits.
REQ-003 SHALL have parameter SYM_TYPE, default 0: 0 = odd symmetry (f(-x) = -f(x)); 1 = point symmetry about (0, 0.5) (f(-x) = 1 - f(x)).
REQ-004 SHALL have parameter DEPTH, default 4, sign-FIFO depth, power of two, at least 2.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port list:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- sign_valid  in  1  folded-axis sign is presented
- sign_in  in  1  sign produced by the axis-fold stage (1 = input was mirrored)
- sign_ready  out  1  sign FIFO can accept
- y_valid  in  1  approximator result is presented
- y_in  in  M+N  signed folded-domain result
- y_ready  out  1  block accepts y_in
- out_valid  out  1  restored result is valid
- out_y  out  M+N  signed restored result
- out_ready  in  1  downstream accepts out_y
- level  out  clog2(DEPTH)+1  current sign-FIFO occupancy
- err  out  1  sticky protocol error

Function
REQ-007 SHALL push sign_in into the FIFO when sign_valid && sign_ready.
REQ-008 sign_ready SHALL be !full, where full means level == DEPTH; no push is accepted while full, even if a pop occurs in the same cycle.
REQ-009 y_ready SHALL be (level != 0) && (!out_valid || out_ready).
REQ-010 On y_valid && y_ready, SHALL pop the oldest sign s and register out_y = R(s, y_in) with out_valid = 1 at the next edge (latency 1 cycle).
REQ-011 R for SYM_TYPE=0 SHALL be s ? -y : y.
REQ-012 R for SYM_TYPE=1 SHALL be s ? (2^N - y) : y.
REQ-013 SHALL compute R at width M+N+1 and then reduce it to M+N as specified in REQ-022 and REQ-023.
REQ-014 When out_valid && out_ready and no new result is loaded, SHALL clear out_valid at the next edge; when a result is loaded in the same cycle, SHALL replace out_y with no bubble.
REQ-015 SHALL hold out_y and out_valid stable while out_valid && !out_ready.
REQ-016 A simultaneous push and pop SHALL leave level unchanged and preserve FIFO order.
REQ-017 Push on an empty FIFO SHALL NOT bypass; the pushed sign is poppable from the next cycle.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH.
REQ-019 SHALL set err when y_valid is high while level == 0, or when sign_valid is high while full; err stays set until reset.

Reset
REQ-020 While rst is high at a clock edge, SHALL set out_valid=0, out_y=0, level=0, both pointers to 0, and err=0.
REQ-021 Reset asserted mid-operation SHALL discard all stored signs and any pending output, and SHALL accept no push or pop in that cycle; sign_ready=1 and y_ready=0 on the cycle after.

Configuration
REQ-022 With macro SYM_RESTORE_SAT_EN defined, SHALL clamp R to [-2^(M+N-1), 2^(M+N-1)-1]; for example, -(-2048) yields 2047 at default widths.
REQ-023 Without SYM_RESTORE_SAT_EN, SHALL truncate R to its low M+N bits (two's-complement wrap); for example, -(-2048) yields -2048.

Verification
REQ-024 Default parameters, reset, push signs 1,0, then y_in = 100 twice -> out_y = -100, then 100, one cycle after each accept; level 2->1->0.
REQ-025 SYM_TYPE=1, push sign 1, y_in = 64 (0.25) -> out_y = 192 (0.75); push sign 0, y_in = 64 -> out_y = 64.
REQ-026 Push 4 signs -> sign_ready=0, level=4; a 5th sign_valid -> err=1 and level stays 4.
REQ-027 Hold out_ready=0 with a valid output -> y_ready=0 and out_y stable; raise out_ready with y_valid high -> back-to-back results, no bubble.
REQ-028 SYM_TYPE=0, sign 1, y_in = -2048 -> out_y = 2047 with SYM_RESTORE_SAT_EN, -2048 without.
REQ-029 Assert rst with level=3 and out_valid=1 -> next cycle level=0, out_valid=0, err=0, sign_ready=1.
